// File: rtl/regfile_wr_arbiter_if.sv
// Writeback bundle between the ALU/memory units, decode stage and register-file write port.
// Carries both request/grant pairs, load-issue tracking, decode source addresses and write-port outputs.
// The arbiter connects through the slave modport; the units and the register file use master.
interface regfile_wr_arbiter_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
);
   localparam int NREGS = 2**ADDR_W;

   logic              alu_req;
   logic [ADDR_W-1:0] alu_addr;
   logic [DATA_W-1:0] alu_data;
   logic              alu_gnt;
   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_gnt;
   logic              load_issue;
   logic [ADDR_W-1:0] load_addr;
   logic [ADDR_W-1:0] rd1address;
   logic [ADDR_W-1:0] rd2address;
   logic              stall;
   logic [DATA_W-1:0] in_data;
   logic [ADDR_W-1:0] inaddress;
   logic              write;
   logic [NREGS-1:0]  busy;
   logic              err;

   modport master (
      output alu_req, alu_addr, alu_data, mem_req, mem_addr, mem_data,
             load_issue, load_addr, rd1address, rd2address,
      input  alu_gnt, mem_gnt, stall, in_data, inaddress, write, busy, err
   );

   modport slave (
      input  alu_req, alu_addr, alu_data, mem_req, mem_addr, mem_data,
             load_issue, load_addr, rd1address, rd2address,
      output alu_gnt, mem_gnt, stall, in_data, inaddress, write, busy, err
   );
endinterface

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the register-file write port between ALU and load return, with load busy scoreboard.
// Latency: grant is combinational; WRITE/IN/INADDRESS follow one edge later; busy bit clears two edges after a MEM grant.
// Backpressure: requesters hold until GNT; ALU is held off while its destination has a pending load; decode stalls on busy sources.
module regfile_wr_arbiter #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 3
) (
   input logic                 i_clock,
   input logic                 i_reset,
   regfile_wr_arbiter_if.slave bus
);
   localparam int   NREGS   = 2**ADDR_W;
   localparam logic SRC_ALU = 1'b0;
   localparam logic SRC_MEM = 1'b1;

   logic              r_last;
   logic              r_src;
   logic              r_write;
   logic              r_err;
   logic [DATA_W-1:0] r_in;
   logic [ADDR_W-1:0] r_inaddress;
   logic [NREGS-1:0]  r_busy;

   logic              w_alu_elig;
   logic              w_mem_elig;
   logic              w_alu_gnt;
   logic              w_mem_gnt;
   logic [NREGS-1:0]  w_clr_vec;
   logic [NREGS-1:0]  w_set_vec;
   logic [NREGS-1:0]  w_busy_nxt;
   logic              w_reissue_err;
   logic              w_mem_err;

   // Eligibility and round-robin grant; the source that did not win last time wins a tie.
   always_comb begin
      w_alu_elig = bus.alu_req & ~r_busy[bus.alu_addr];
      w_mem_elig = bus.mem_req;
      w_alu_gnt  = ~i_reset & w_alu_elig & (~w_mem_elig | (r_last == SRC_MEM));
      w_mem_gnt  = ~i_reset & w_mem_elig & (~w_alu_elig | (r_last == SRC_ALU));
   end

   // Scoreboard next state: clear lands at the end of a MEM write pulse, a new load issue overrides it.
   always_comb begin
      w_clr_vec = '0;
      if (r_write && (r_src == SRC_MEM)) begin
         w_clr_vec[r_inaddress] = 1'b1;
      end
      w_set_vec = '0;
      if (bus.load_issue) begin
         w_set_vec[bus.load_addr] = 1'b1;
      end
      w_busy_nxt    = (r_busy & ~w_clr_vec) | w_set_vec;
      w_reissue_err = bus.load_issue & r_busy[bus.load_addr] & ~w_clr_vec[bus.load_addr];
      w_mem_err     = w_mem_gnt & ~r_busy[bus.mem_addr];
   end

   // Write-port registers, source tag, round-robin pointer, scoreboard and sticky error.
   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_last      <= SRC_MEM;
         r_src       <= SRC_ALU;
         r_write     <= 1'b0;
         r_err       <= 1'b0;
         r_in        <= '0;
         r_inaddress <= '0;
         r_busy      <= '0;
      end else begin
         r_write <= w_alu_gnt | w_mem_gnt;
         if (w_alu_gnt) begin
            r_in        <= bus.alu_data;
            r_inaddress <= bus.alu_addr;
            r_src       <= SRC_ALU;
            r_last      <= SRC_ALU;
         end else if (w_mem_gnt) begin
            r_in        <= bus.mem_data;
            r_inaddress <= bus.mem_addr;
            r_src       <= SRC_MEM;
            r_last      <= SRC_MEM;
         end
         r_busy <= w_busy_nxt;
         if (w_reissue_err || w_mem_err) begin
            r_err <= 1'b1;
         end
      end
   end

   assign bus.alu_gnt   = w_alu_gnt;
   assign bus.mem_gnt   = w_mem_gnt;
   assign bus.stall     = r_busy[bus.rd1address] | r_busy[bus.rd2address];
   assign bus.in_data   = r_in;
   assign bus.inaddress = r_inaddress;
   assign bus.write     = r_write;
   assign bus.busy      = r_busy;
   assign bus.err       = r_err;
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Directed bench for regfile_wr_arbiter with a cycle-level behavioural model and literal spot checks.
// Inputs change 1 time unit after the rising edge; outputs are compared against the model on the falling edge.
// Literal expectations from the worked scenarios pin the model as well as the design.
module tb_regfile_wr_arbiter;
   logic clk;
   logic rst;
   int   errors;
   int   checks;

   regfile_wr_arbiter_if #(.DATA_W(8), .ADDR_W(3)) bus ();

   regfile_wr_arbiter #(.DATA_W(8), .ADDR_W(3)) dut (
      .i_clock (clk),
      .i_reset (rst),
      .bus     (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [7:0] m_busy;
   logic       m_last_mem;
   logic       m_err;
   logic       m_write;
   logic [7:0] m_in;
   logic [2:0] m_addr;
   int         m_clr_due [8];
   int         edge_no;
   bit         cmp_en;

   function automatic logic model_alu_gnt();
      logic ea, em;
      ea = bus.alu_req && !m_busy[bus.alu_addr];
      em = bus.mem_req;
      return !rst && ea && (!em || m_last_mem);
   endfunction

   function automatic logic model_mem_gnt();
      logic ea, em;
      ea = bus.alu_req && !m_busy[bus.alu_addr];
      em = bus.mem_req;
      return !rst && em && (!ea || !m_last_mem);
   endfunction

   initial begin
      m_busy = '0; m_last_mem = 1'b1; m_err = 1'b0; m_write = 1'b0;
      m_in = '0; m_addr = '0; edge_no = 0; cmp_en = 1'b0;
      for (int i = 0; i < 8; i++) m_clr_due[i] = -1;
   end

   always @(posedge clk) begin
      logic ga, gm;
      edge_no++;
      if (rst) begin
         m_busy = '0; m_last_mem = 1'b1; m_err = 1'b0; m_write = 1'b0;
         m_in = '0; m_addr = '0;
         for (int i = 0; i < 8; i++) m_clr_due[i] = -1;
         cmp_en = 1'b1;
      end else begin
         ga = model_alu_gnt();
         gm = model_mem_gnt();
         if (bus.load_issue && m_busy[bus.load_addr] && m_clr_due[bus.load_addr] != edge_no) m_err = 1'b1;
         if (gm && !m_busy[bus.mem_addr]) m_err = 1'b1;
         for (int i = 0; i < 8; i++) begin
            if (m_clr_due[i] == edge_no) begin
               m_busy[i] = 1'b0;
               m_clr_due[i] = -1;
            end
         end
         if (bus.load_issue) m_busy[bus.load_addr] = 1'b1;
         if (gm) m_clr_due[bus.mem_addr] = edge_no + 1;
         m_write = ga || gm;
         if (ga) begin
            m_in = bus.alu_data; m_addr = bus.alu_addr; m_last_mem = 1'b0;
         end else if (gm) begin
            m_in = bus.mem_data; m_addr = bus.mem_addr; m_last_mem = 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("mdl_alu_gnt", bus.alu_gnt, model_alu_gnt());
         chk("mdl_mem_gnt", bus.mem_gnt, model_mem_gnt());
         chk("mdl_write",   bus.write,   m_write);
         chk("mdl_in",      bus.in_data, m_in);
         chk("mdl_inaddr",  bus.inaddress, m_addr);
         chk("mdl_busy",    bus.busy,    m_busy);
         chk("mdl_err",     bus.err,     m_err);
         chk("mdl_stall",   bus.stall,   m_busy[bus.rd1address] | m_busy[bus.rd2address]);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #3;
   endtask

   task automatic clear_inputs();
      bus.alu_req = 0; bus.alu_addr = 0; bus.alu_data = 0;
      bus.mem_req = 0; bus.mem_addr = 0; bus.mem_data = 0;
      bus.load_issue = 0; bus.load_addr = 0;
      bus.rd1address = 0; bus.rd2address = 0;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      clear_inputs();
      step();
      step();
      rst = 1'b0;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      clear_inputs();

      // Reset then idle
      reset_dut();
      step(); step(); step();
      settle();
      chk("idle_write", bus.write, 0);
      chk("idle_in", bus.in_data, 0);
      chk("idle_inaddr", bus.inaddress, 0);
      chk("idle_busy", bus.busy, 8'h00);
      chk("idle_err", bus.err, 0);
      chk("idle_stall", bus.stall, 0);
      chk("idle_gnts", {bus.alu_gnt, bus.mem_gnt}, 2'b00);

      // Single ALU write
      bus.alu_req = 1; bus.alu_addr = 3; bus.alu_data = 8'h5A;
      settle();
      chk("alu_gnt", bus.alu_gnt, 1);
      step();
      bus.alu_req = 0;
      settle();
      chk("alu_write", bus.write, 1);
      chk("alu_inaddr", bus.inaddress, 3);
      chk("alu_in", bus.in_data, 8'h5A);
      step();
      settle();
      chk("alu_write_drop", bus.write, 0);

      // Continuous contention alternates ALU, MEM
      reset_dut();
      bus.alu_req = 1; bus.alu_addr = 1; bus.alu_data = 8'h11;
      bus.mem_req = 1; bus.mem_addr = 2; bus.mem_data = 8'h22;
      for (int i = 0; i < 4; i++) begin
         settle();
         chk("rr_alu_gnt", bus.alu_gnt, (i % 2 == 0) ? 1 : 0);
         chk("rr_mem_gnt", bus.mem_gnt, (i % 2 == 1) ? 1 : 0);
         if (i > 0) begin
            chk("rr_write", bus.write, 1);
            chk("rr_inaddr", bus.inaddress, (i % 2 == 1) ? 1 : 2);
            chk("rr_in", bus.in_data, (i % 2 == 1) ? 8'h11 : 8'h22);
         end
         step();
      end
      bus.alu_req = 0; bus.mem_req = 0;
      settle();
      chk("rr_last_write", bus.write, 1);
      chk("rr_last_inaddr", bus.inaddress, 2);

      // Load scoreboard, ALU blocking and release
      reset_dut();
      bus.load_issue = 1; bus.load_addr = 5;
      step();
      bus.load_issue = 0; bus.rd1address = 5; bus.rd2address = 0;
      bus.alu_req = 1; bus.alu_addr = 5; bus.alu_data = 8'h77;
      settle();
      chk("ld_busy", bus.busy, 8'h20);
      chk("ld_stall", bus.stall, 1);
      chk("ld_alu_blocked", bus.alu_gnt, 0);
      step();
      bus.mem_req = 1; bus.mem_addr = 5; bus.mem_data = 8'hC3;
      settle();
      chk("ld_mem_gnt", bus.mem_gnt, 1);
      chk("ld_alu_blocked2", bus.alu_gnt, 0);
      step();
      bus.mem_req = 0;
      settle();
      chk("ld_write", bus.write, 1);
      chk("ld_in", bus.in_data, 8'hC3);
      chk("ld_inaddr", bus.inaddress, 5);
      chk("ld_busy_hold", bus.busy, 8'h20);
      chk("ld_stall_hold", bus.stall, 1);
      chk("ld_alu_blocked3", bus.alu_gnt, 0);
      step();
      settle();
      chk("ld_busy_clr", bus.busy, 8'h00);
      chk("ld_stall_clr", bus.stall, 0);
      chk("ld_alu_gnt", bus.alu_gnt, 1);
      step();
      bus.alu_req = 0;
      settle();
      chk("ld_alu_write", bus.write, 1);
      chk("ld_alu_in", bus.in_data, 8'h77);
      chk("ld_err_clean", bus.err, 0);

      // Reissue to busy register, then MEM to non-busy register
      bus.load_issue = 1; bus.load_addr = 5;
      step();
      step();
      bus.load_issue = 0;
      settle();
      chk("err_reissue", bus.err, 1);
      chk("err_busy", bus.busy, 8'h20);
      bus.mem_req = 1; bus.mem_addr = 6; bus.mem_data = 8'h66;
      settle();
      chk("err_mem_gnt", bus.mem_gnt, 1);
      step();
      bus.mem_req = 0;
      settle();
      chk("err_mem_write", bus.write, 1);
      chk("err_mem_inaddr", bus.inaddress, 6);
      chk("err_mem_in", bus.in_data, 8'h66);
      chk("err_sticky", bus.err, 1);

      // Reset right after a grant, with BUSY=0F and ERR set
      reset_dut();
      for (int i = 0; i < 4; i++) begin
         bus.load_issue = 1; bus.load_addr = 3'(i);
         step();
      end
      bus.load_addr = 0;
      step();
      bus.load_issue = 0;
      bus.alu_req = 1; bus.alu_addr = 7; bus.alu_data = 8'h99;
      settle();
      chk("rst_pre_busy", bus.busy, 8'h0F);
      chk("rst_pre_err", bus.err, 1);
      chk("rst_pre_gnt", bus.alu_gnt, 1);
      step();
      rst = 1;
      bus.alu_req = 1; bus.alu_addr = 1; bus.alu_data = 8'hAA;
      bus.mem_req = 1; bus.mem_addr = 2; bus.mem_data = 8'hBB;
      settle();
      chk("rst_in_write", bus.write, 1);
      chk("rst_gnts_forced", {bus.alu_gnt, bus.mem_gnt}, 2'b00);
      step();
      rst = 0;
      settle();
      chk("rst_write", bus.write, 0);
      chk("rst_busy", bus.busy, 8'h00);
      chk("rst_err", bus.err, 0);
      chk("rst_tie_alu", bus.alu_gnt, 1);
      chk("rst_tie_mem", bus.mem_gnt, 0);
      step();
      bus.alu_req = 0;
      settle();
      chk("rst_mem_next", bus.mem_gnt, 1);
      chk("rst_alu_in", bus.in_data, 8'hAA);
      step();
      bus.mem_req = 0;
      step();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
